// File: rtl/kpp_trace_pkg.sv
//------------------------------------------------------------------------------
// Module   : kpp_trace_pkg
// Brief    : Shared types and constants for the KPP waypoint tracer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package kpp_trace_pkg;

    localparam int KPP_WP_W  = 640;
    localparam int KPP_CNT_W = 32;

    localparam logic [7:0] KPP_ABEND_RUNNING = 8'hFF;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        FIN = 1'b1
    } kpp_trace_state_t;

    typedef struct packed {
        logic [KPP_WP_W-1:0]  wp;
        logic [KPP_CNT_W-1:0] stamp;
        logic [KPP_CNT_W-1:0] delta;
    } kpp_trace_rec_t;

endpackage

`default_nettype wire

// File: rtl/kpp_trace_fifo.sv
//------------------------------------------------------------------------------
// Module   : kpp_trace_fifo
// Brief    : First-word-fall-through record FIFO, MSB-wrap pointers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module kpp_trace_fifo
    import kpp_trace_pkg::*;
#(
    parameter type REC_T = kpp_trace_rec_t,
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  REC_T                     push_data,
    output logic                     full,
    input  logic                     pop,
    output REC_T                     pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    REC_T        r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
                r_wr_ptr                <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/kpp_waypoint_tracer.sv
//------------------------------------------------------------------------------
// Module   : kpp_waypoint_tracer
// Brief    : Timestamps DUT waypoint changes into a FIFO and latches the abend.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module kpp_waypoint_tracer
    import kpp_trace_pkg::*;
#(
    parameter int WP_W   = 640,
    parameter int CNT_W  = 32,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WP_W-1:0]   wp_in,
    input  logic [7:0]        abend_in,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [WP_W-1:0]   rec_wp,
    output logic [CNT_W-1:0]  rec_stamp,
    output logic [CNT_W-1:0]  rec_delta,
    output logic              finished,
    output logic [7:0]        abend_code,
    output logic [CNT_W-1:0]  finish_cycle,
    output logic              drained,
    output logic [DROP_W-1:0] dropped
);

    typedef struct packed {
        logic [WP_W-1:0]  wp;
        logic [CNT_W-1:0] stamp;
        logic [CNT_W-1:0] delta;
    } rec_t;

    localparam logic [CNT_W-1:0]  c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] c_drop_one = {{(DROP_W-1){1'b0}}, 1'b1};

    kpp_trace_state_t       r_state;
    kpp_trace_state_t       w_state_nxt;
    logic                   w_run;
    logic                   w_fin;

    logic [CNT_W-1:0]       r_cycle;
    logic [CNT_W-1:0]       r_last;
    logic [WP_W-1:0]        r_prev_wp;
    logic                   r_first;
    logic [7:0]             r_abend_code;
    logic [CNT_W-1:0]       r_finish_cycle;
    logic [DROP_W-1:0]      r_dropped;

    logic                   w_change;
    logic                   w_push;
    logic                   w_finish;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    rec_t                   w_rec;
    rec_t                   w_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (abend_in != KPP_ABEND_RUNNING) w_state_nxt = FIN;
            FIN:     w_state_nxt = FIN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_run = 1'b0;
        w_fin = 1'b0;
        case (r_state)
            RUN:     w_run = 1'b1;
            FIN:     w_fin = 1'b1;
            default: w_run = 1'b0;
        endcase
    end

    // The first RUN cycle counts as a change so a non-zero initial waypoint is traced.
    assign w_change = w_run && (r_first || (wp_in != r_prev_wp));
    assign w_push   = w_change && (wp_in != '0);
    assign w_finish = w_run && (abend_in != KPP_ABEND_RUNNING);
    assign w_pop    = rec_valid && rec_ready;
    assign w_drop   = w_push && w_full && !w_pop;

    always_comb begin
        w_rec       = '0;
        w_rec.wp    = wp_in;
        w_rec.stamp = r_cycle;
        w_rec.delta = r_cycle - r_last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle        <= '0;
            r_last         <= '0;
            r_prev_wp      <= '0;
            r_first        <= 1'b1;
            r_abend_code   <= KPP_ABEND_RUNNING;
            r_finish_cycle <= '0;
            r_dropped      <= '0;
        end else begin
            if (w_run) begin
                r_first <= 1'b0;
                if (r_cycle != '1) begin
                    r_cycle <= r_cycle + c_cnt_one;
                end
            end
            if (w_change) begin
                r_prev_wp <= wp_in;
                r_last    <= r_cycle;
            end
            if (w_finish) begin
                r_abend_code   <= abend_in;
                r_finish_cycle <= r_cycle;
            end
            if (w_drop && (r_dropped != '1)) begin
                r_dropped <= r_dropped + c_drop_one;
            end
        end
    end

    kpp_trace_fifo #(
        .REC_T (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_rec),
        .full      (w_full),
        .pop       (w_pop),
        .pop_data  (w_head),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign rec_valid    = (w_count != '0);
    assign rec_wp       = w_head.wp;
    assign rec_stamp    = w_head.stamp;
    assign rec_delta    = w_head.delta;
    assign finished     = w_fin;
    assign abend_code   = r_abend_code;
    assign finish_cycle = r_finish_cycle;
    assign drained      = w_fin && w_empty;
    assign dropped      = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_kpp_waypoint_tracer.sv
//------------------------------------------------------------------------------
// Module   : tb_kpp_waypoint_tracer
// Brief    : Directed self-checking bench for kpp_waypoint_tracer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_kpp_waypoint_tracer;

    logic         clk;
    logic         reset;
    logic [639:0] wp_in;
    logic [7:0]   abend_in;
    logic         rec_valid;
    logic         rec_ready;
    logic [639:0] rec_wp;
    logic [31:0]  rec_stamp;
    logic [31:0]  rec_delta;
    logic         finished;
    logic [7:0]   abend_code;
    logic [31:0]  finish_cycle;
    logic         drained;
    logic [15:0]  dropped;

    // Narrow-counter instance for saturation behaviour.
    logic         reset8;
    logic [639:0] wp8;
    logic [7:0]   ab8;
    logic         valid8;
    logic         ready8;
    logic [639:0] wp8_out;
    logic [7:0]   stamp8;
    logic [7:0]   delta8;
    logic         fin8;
    logic [7:0]   code8;
    logic [7:0]   fcyc8;
    logic         drained8;
    logic [15:0]  dropped8;

    int n_checks;
    int n_fail;

    kpp_waypoint_tracer dut (
        .clk          (clk),
        .reset        (reset),
        .wp_in        (wp_in),
        .abend_in     (abend_in),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_wp       (rec_wp),
        .rec_stamp    (rec_stamp),
        .rec_delta    (rec_delta),
        .finished     (finished),
        .abend_code   (abend_code),
        .finish_cycle (finish_cycle),
        .drained      (drained),
        .dropped      (dropped)
    );

    kpp_waypoint_tracer #(.CNT_W(8)) dut8 (
        .clk          (clk),
        .reset        (reset8),
        .wp_in        (wp8),
        .abend_in     (ab8),
        .rec_valid    (valid8),
        .rec_ready    (ready8),
        .rec_wp       (wp8_out),
        .rec_stamp    (stamp8),
        .rec_delta    (delta8),
        .finished     (fin8),
        .abend_code   (code8),
        .finish_cycle (fcyc8),
        .drained      (drained8),
        .dropped      (dropped8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the DUT in cycle 0 of RUN, one time unit after a rising edge.
    task automatic do_reset();
        reset     = 1'b1;
        wp_in     = '0;
        abend_in  = 8'hFF;
        rec_ready = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (rec_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_valid: got %b want 0", rec_valid); end
        n_checks++; if (rec_wp !== 640'h0)      begin n_fail++; $display("FAIL reset_wp: got %0h want 0", rec_wp); end
        n_checks++; if (rec_stamp !== 32'd0)    begin n_fail++; $display("FAIL reset_stamp: got %0d want 0", rec_stamp); end
        n_checks++; if (rec_delta !== 32'd0)    begin n_fail++; $display("FAIL reset_delta: got %0d want 0", rec_delta); end
        n_checks++; if (finished !== 1'b0)      begin n_fail++; $display("FAIL reset_finished: got %b want 0", finished); end
        n_checks++; if (abend_code !== 8'hFF)   begin n_fail++; $display("FAIL reset_abend: got %h want ff", abend_code); end
        n_checks++; if (finish_cycle !== 32'd0) begin n_fail++; $display("FAIL reset_fcycle: got %0d want 0", finish_cycle); end
        n_checks++; if (drained !== 1'b0)       begin n_fail++; $display("FAIL reset_drained: got %b want 0", drained); end
        n_checks++; if (dropped !== 16'd0)      begin n_fail++; $display("FAIL reset_dropped: got %0d want 0", dropped); end
    endtask

    task automatic test_basic();
        do_reset();
        step(5);
        n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid: got %b want 0", rec_valid); end
        wp_in = 640'h41;
        step(1);
        n_checks++; if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL basic_a_valid: got %b want 1", rec_valid); end
        n_checks++; if (rec_wp !== 640'h41 || rec_stamp !== 32'd5 || rec_delta !== 32'd5)
            begin n_fail++; $display("FAIL basic_a_rec: got (%0h,%0d,%0d) want (41,5,5)", rec_wp, rec_stamp, rec_delta); end
        step(6);
        wp_in = 640'h42;
        step(1);
        n_checks++; if (rec_wp !== 640'h41 || rec_stamp !== 32'd5)
            begin n_fail++; $display("FAIL basic_head_hold: got (%0h,%0d) want (41,5)", rec_wp, rec_stamp); end
        rec_ready = 1'b1;
        step(1);
        n_checks++; if (rec_valid !== 1'b1 || rec_wp !== 640'h42 || rec_stamp !== 32'd12 || rec_delta !== 32'd7)
            begin n_fail++; $display("FAIL basic_b_rec: got v=%b (%0h,%0d,%0d) want v=1 (42,12,7)", rec_valid, rec_wp, rec_stamp, rec_delta); end
        step(1);
        n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b want 0", rec_valid); end
        rec_ready = 1'b0;
    endtask

    task automatic test_zero_wp();
        do_reset();
        step(3);
        wp_in = 640'h41;
        step(1);
        wp_in = 640'h0;
        step(5);
        wp_in = 640'h41;
        step(1);
        n_checks++; if (rec_wp !== 640'h41 || rec_stamp !== 32'd3 || rec_delta !== 32'd3)
            begin n_fail++; $display("FAIL zero_first: got (%0h,%0d,%0d) want (41,3,3)", rec_wp, rec_stamp, rec_delta); end
        rec_ready = 1'b1;
        step(1);
        n_checks++; if (rec_valid !== 1'b1 || rec_wp !== 640'h41 || rec_stamp !== 32'd9 || rec_delta !== 32'd5)
            begin n_fail++; $display("FAIL zero_second: got v=%b (%0h,%0d,%0d) want v=1 (41,9,5)", rec_valid, rec_wp, rec_stamp, rec_delta); end
        step(1);
        n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL zero_no_extra: got %b want 0", rec_valid); end
        rec_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [639:0] exp_wp [4];
        logic [31:0]  exp_st [4];
        exp_wp = '{640'h2, 640'h3, 640'h4, 640'h7};
        exp_st = '{32'd1, 32'd2, 32'd3, 32'd6};
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            wp_in = 640'(i);
            step(1);
        end
        n_checks++; if (dropped !== 16'd2) begin n_fail++; $display("FAIL ovf_dropped: got %0d want 2", dropped); end
        n_checks++; if (rec_wp !== 640'h1 || rec_stamp !== 32'd0 || rec_delta !== 32'd0)
            begin n_fail++; $display("FAIL ovf_head: got (%0h,%0d,%0d) want (1,0,0)", rec_wp, rec_stamp, rec_delta); end
        wp_in     = 640'h7;
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            n_checks++; if (rec_valid !== 1'b1 || rec_wp !== exp_wp[i] || rec_stamp !== exp_st[i] || rec_delta !== 32'd1)
                begin n_fail++; $display("FAIL ovf_order%0d: got v=%b (%0h,%0d,%0d) want v=1 (%0h,%0d,1)", i, rec_valid, rec_wp, rec_stamp, rec_delta, exp_wp[i], exp_st[i]); end
        end
        step(1);
        n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", rec_valid); end
        n_checks++; if (dropped !== 16'd2) begin n_fail++; $display("FAIL ovf_dropped_end: got %0d want 2", dropped); end
        rec_ready = 1'b0;
    endtask

    task automatic test_abend();
        do_reset();
        step(20);
        wp_in    = 640'h5A;
        abend_in = 8'h00;
        step(1);
        n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL abend_finished: got %b want 1", finished); end
        n_checks++; if (abend_code !== 8'h00 || finish_cycle !== 32'd20)
            begin n_fail++; $display("FAIL abend_latch: got (%h,%0d) want (00,20)", abend_code, finish_cycle); end
        n_checks++; if (rec_valid !== 1'b1 || rec_wp !== 640'h5A || rec_stamp !== 32'd20)
            begin n_fail++; $display("FAIL abend_rec: got v=%b (%0h,%0d) want v=1 (5a,20)", rec_valid, rec_wp, rec_stamp); end
        n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL abend_not_drained: got %b want 0", drained); end
        wp_in    = 640'h59;
        abend_in = 8'h05;
        step(3);
        n_checks++; if (abend_code !== 8'h00 || finish_cycle !== 32'd20)
            begin n_fail++; $display("FAIL abend_ignored: got (%h,%0d) want (00,20)", abend_code, finish_cycle); end
        rec_ready = 1'b1;
        step(1);
        n_checks++; if (rec_valid !== 1'b0 || drained !== 1'b1)
            begin n_fail++; $display("FAIL abend_drain: got valid=%b drained=%b want 0,1", rec_valid, drained); end
        rec_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        wp_in = 640'h1; step(1);
        wp_in = 640'h2; step(1);
        wp_in = 640'h3; step(1);
        abend_in = 8'h00; step(1);
        n_checks++; if (rec_valid !== 1'b1 || finished !== 1'b1)
            begin n_fail++; $display("FAIL areset_pre: got valid=%b finished=%b want 1,1", rec_valid, finished); end
        #3;
        reset = 1'b1;
        #1;
        n_checks++; if (rec_valid !== 1'b0 || rec_wp !== 640'h0 || rec_stamp !== 32'd0 || rec_delta !== 32'd0)
            begin n_fail++; $display("FAIL areset_rec: got v=%b (%0h,%0d,%0d) want v=0 (0,0,0)", rec_valid, rec_wp, rec_stamp, rec_delta); end
        n_checks++; if (finished !== 1'b0 || abend_code !== 8'hFF || finish_cycle !== 32'd0 || drained !== 1'b0 || dropped !== 16'd0)
            begin n_fail++; $display("FAIL areset_status: got fin=%b code=%h fc=%0d dr=%b drop=%0d want 0,ff,0,0,0", finished, abend_code, finish_cycle, drained, dropped); end
        abend_in = 8'hFF;
        wp_in    = 640'h0;
        step(1);
        reset = 1'b0;
        step(2);
        wp_in = 640'h41;
        step(1);
        n_checks++; if (rec_valid !== 1'b1 || rec_stamp !== 32'd2 || rec_delta !== 32'd2)
            begin n_fail++; $display("FAIL areset_restart: got v=%b (%0d,%0d) want v=1 (2,2)", rec_valid, rec_stamp, rec_delta); end
    endtask

    task automatic test_saturate();
        reset8 = 1'b1;
        wp8    = '0;
        ab8    = 8'hFF;
        ready8 = 1'b0;
        step(1);
        reset8 = 1'b0;
        step(200);
        wp8 = 640'h1;
        step(1);
        n_checks++; if (valid8 !== 1'b1 || stamp8 !== 8'd200 || delta8 !== 8'd200)
            begin n_fail++; $display("FAIL sat_first: got v=%b (%0d,%0d) want v=1 (200,200)", valid8, stamp8, delta8); end
        ready8 = 1'b1;
        step(1);
        ready8 = 1'b0;
        step(100);
        wp8 = 640'h2;
        step(1);
        n_checks++; if (wp8_out !== 640'h2 || stamp8 !== 8'd255 || delta8 !== 8'd55)
            begin n_fail++; $display("FAIL sat_stamp: got (%0h,%0d,%0d) want (2,255,55)", wp8_out, stamp8, delta8); end
        ready8 = 1'b1;
        wp8    = 640'h3;
        step(1);
        n_checks++; if (valid8 !== 1'b1 || wp8_out !== 640'h3 || stamp8 !== 8'd255 || delta8 !== 8'd0)
            begin n_fail++; $display("FAIL sat_delta: got v=%b (%0h,%0d,%0d) want v=1 (3,255,0)", valid8, wp8_out, stamp8, delta8); end
        ab8 = 8'h00;
        step(1);
        n_checks++; if (fin8 !== 1'b1 || fcyc8 !== 8'd255)
            begin n_fail++; $display("FAIL sat_finish: got fin=%b fc=%0d want 1,255", fin8, fcyc8); end
        ready8 = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        reset8    = 1'b1;
        wp_in     = '0;
        abend_in  = 8'hFF;
        rec_ready = 1'b0;
        wp8       = '0;
        ab8       = 8'hFF;
        ready8    = 1'b0;
        test_reset();
        test_basic();
        test_zero_wp();
        test_overflow();
        test_abend();
        test_async_reset();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
